// File: rtl/blake2_msg_packer.sv
// blake2_msg_packer
//   Feeds the blake2 compression core. Collects 8-byte little-endian input
//   beats into BB-byte message blocks, zero-pads the final block, and hands
//   each block to the core with first/last flags and the running byte count.
//   It then waits for the core's done pulse before building the next block.
//
// Ports
//   clk           clock, all logic on the rising edge
//   nreset        synchronous active-low reset
//   data_valid_i  input beat valid
//   data_ready_o  high while a beat can be accepted (FILL state)
//   data_i        beat data, byte k at [8k+7:8k]
//   data_bytes_i  number of valid low-aligned bytes in the beat (0..8)
//   data_last_i   beat is the final beat of the message
//   blk_valid_o   one-cycle pulse presenting a block to the core
//   blk_first_o   presented block is the first of its message
//   blk_last_o    presented block is the last of its message
//   blk_d_o       block contents, message byte i at [8i+7:8i]
//   blk_ll_o      message bytes up to and including this block
//   core_done_i   core has consumed the presented block
//   proto_err_o   sticky flag for malformed input beats
module blake2_msg_packer #(
  parameter int W  = 64,
  parameter int BB = W * 2
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            data_valid_i,
  output logic            data_ready_o,
  input  logic [63:0]     data_i,
  input  logic [3:0]      data_bytes_i,
  input  logic            data_last_i,
  output logic            blk_valid_o,
  output logic            blk_first_o,
  output logic            blk_last_o,
  output logic [W*16-1:0] blk_d_o,
  output logic [63:0]     blk_ll_o,
  input  logic            core_done_i,
  output logic            proto_err_o
);

  localparam int BEATS = BB / 8;
  localparam int BI    = $clog2(BEATS);
  localparam int PW    = $clog2(BB) + 1;
  localparam logic [PW-1:0] BB_PTR = BB[PW-1:0];

  typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;

  state_t        state_q;
  logic [63:0]   buf_q [BEATS];
  logic [PW-1:0] ptr_q;
  logic [63:0]   ll_q;
  logic          first_q;
  logic          last_q;
  logic [63:0]   blk_ll_q;
  logic          err_q;

  logic          accept;
  logic          msg_first;
  logic          bytes_gt8;
  logic [3:0]    n_eff;
  logic          beat_err;
  logic [63:0]   beat_data;
  logic [PW-1:0] ptr_d;
  logic [63:0]   ll_d;
  logic          blk_done;

  assign accept    = data_valid_i && (state_q == FILL);
  // No byte of the current message has been taken yet.
  assign msg_first = first_q && (ptr_q == '0);
  assign bytes_gt8 = data_bytes_i > 4'd8;
  // Only a final beat may be short; anything else is forced to a full beat.
  assign n_eff     = (bytes_gt8 || !data_last_i) ? 4'd8 : data_bytes_i;
  assign beat_err  = bytes_gt8
                   || (!data_last_i && (data_bytes_i != 4'd8))
                   || (data_last_i && (data_bytes_i == 4'd0) && !msg_first);
  assign ptr_d     = ptr_q + {{(PW-4){1'b0}}, n_eff};
  assign ll_d      = ll_q + {60'd0, n_eff};
  assign blk_done  = (ptr_d == BB_PTR) || data_last_i;

  // Bytes beyond the valid count are written as zero so the block is padded.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign beat_data[8*gi +: 8] = (4'(gi) < n_eff) ? data_i[8*gi +: 8] : 8'h00;
    end
    for (gi = 0; gi < BEATS; gi++) begin : g_out
      assign blk_d_o[64*gi +: 64] = buf_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q  <= FILL;
      ptr_q    <= '0;
      ll_q     <= '0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      blk_ll_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            // ptr is always beat-aligned here, so a beat fills one slot.
            buf_q[ptr_q[BI+2:3]] <= beat_data;
            ptr_q <= ptr_d;
            ll_q  <= ll_d;
            if (beat_err) err_q <= 1'b1;
            if (blk_done) begin
              last_q   <= data_last_i;
              blk_ll_q <= ll_d;
              state_q  <= SEND;
            end
          end
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (core_done_i) begin
            for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
            ptr_q <= '0;
            if (last_q) begin
              first_q <= 1'b1;
              ll_q    <= '0;
            end else begin
              first_q <= 1'b0;
            end
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign data_ready_o = (state_q == FILL);
  assign blk_valid_o  = (state_q == SEND);
  assign blk_first_o  = first_q;
  assign blk_last_o   = last_q;
  assign blk_ll_o     = blk_ll_q;
  assign proto_err_o  = err_q;

endmodule
